run_ctrl: RTL and testbench

Host-side initiator for the processor's req/done run handshake. It preloads data memory from a host write stream, holds the processor in reset, releases it and pulses req, then waits for done or a timeout. It then freezes the processor and streams a result window of data memory back to the host. It sits beside the processor core in the test harness and FPGA wrapper, sharing the data-memory port through a mux.

---
 rtl/run_ctrl_pkg.sv | 19 +
 rtl/run_ctrl_timer.sv | 36 +++
 rtl/run_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_run_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizes for the run_ctrl host-side run initiator.
package run_ctrl_pkg;

    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int RST_CYC_DEF = 2;
    localparam int TW_DEF      = 16;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRST  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/run_ctrl_timer.sv
// rc_timer: loadable up-counter with synchronous clear, enable and terminal-count flag.
module rc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    // Counter register; clear beats load beats enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {W{1'b0}};
        end else if (clr) begin
            cnt_q <= {W{1'b0}};
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: preload, reset/release, run with timeout, then drain a result window.
// Optional macro RUN_CTRL_CYCLE_CNT_EN adds the cycles output (RUN length latch).
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RST_CYC = RST_CYC_DEF,
    parameter int TW      = TW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_count,
    output logic          busy,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          proc_reset,
    output logic          req,
    input  logic          proc_done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          fin,
    output logic          timeout
`ifdef RUN_CTRL_CYCLE_CNT_EN
    ,
    output logic [TW-1:0] cycles
`endif
);

    localparam int          CW        = AW + 1;
    localparam logic [TW-1:0] PRST_LAST = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] RUN_LAST  = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic [AW-1:0] rd_base_q;
    logic [CW-1:0] rd_count_q;
    logic          timeout_q;

    logic          tmr_clr_s;
    logic          tmr_en_s;
    logic [TW-1:0] tmr_tc_val_s;
    logic [TW-1:0] tmr_cnt_s;
    logic          tmr_tc_s;

    logic          idx_clr_s;
    logic [CW-1:0] idx_tc_val_s;
    logic [CW-1:0] idx_cnt_s;
    logic          idx_tc_s;

    logic [CW-1:0] rd_addr_s;
    logic          rd_addr_unused_s;

    // One timer serves PRST (hold length) and RUN (timeout); it restarts at each phase entry.
    always_comb begin
        tmr_en_s     = (state_q == PRST) || (state_q == RUN);
        tmr_clr_s    = !tmr_en_s || ((state_q == PRST) && tmr_tc_s);
        tmr_tc_val_s = (state_q == PRST) ? PRST_LAST : RUN_LAST;
        idx_clr_s    = (state_q != DRAIN);
        idx_tc_val_s = rd_count_q - CW'(1);
    end

    rc_timer #(.W(TW)) u_run_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (tmr_clr_s),
        .load     (1'b0),
        .load_val ({TW{1'b0}}),
        .en       (tmr_en_s),
        .tc_val   (tmr_tc_val_s),
        .cnt      (tmr_cnt_s),
        .tc       (tmr_tc_s)
    );

    rc_timer #(.W(CW)) u_idx_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (idx_clr_s),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       (res_ready),
        .tc_val   (idx_tc_val_s),
        .cnt      (idx_cnt_s),
        .tc       (idx_tc_s)
    );

    // Sequencer: state, captured window and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_base_q  <= {AW{1'b0}};
            rd_count_q <= {CW{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_base_q  <= rd_base;
                        rd_count_q <= rd_count;
                        timeout_q  <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_last) begin
                        state_q <= PRST;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                PRST: begin
                    if (tmr_tc_s) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= PRST;
                    end
                end
                RUN: begin
                    // done takes priority over a coincident timeout
                    if (proc_done) begin
                        state_q <= (rd_count_q == {CW{1'b0}}) ? FIN : DRAIN;
                    end else if (tmr_tc_s) begin
                        timeout_q <= 1'b1;
                        state_q   <= FIN;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DRAIN: begin
                    if (res_ready && idx_tc_s) begin
                        state_q <= FIN;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr_s        = {1'b0, rd_base_q} + idx_cnt_s;
    assign rd_addr_unused_s = rd_addr_s[AW];

    assign busy       = (state_q != IDLE);
    assign ld_ready   = (state_q == LOAD);
    assign mem_wr_en  = ld_ready && ld_valid;
    assign mem_addr   = (state_q == LOAD)  ? ld_addr :
                        (state_q == DRAIN) ? rd_addr_s[AW-1:0] : {AW{1'b0}};
    assign mem_wdata  = (state_q == LOAD)  ? ld_data : {DW{1'b0}};
    assign proc_reset = (state_q != RUN);
    assign req        = (state_q == RUN) && (tmr_cnt_s == {TW{1'b0}});
    assign res_valid  = (state_q == DRAIN);
    assign res_data   = (state_q == DRAIN) ? mem_rdata : {DW{1'b0}};
    assign fin        = (state_q == FIN);
    assign timeout    = timeout_q;

`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [TW-1:0] cycles_q;

    // Latch RUN length (req cycle through done/timeout cycle) on leaving RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycles_q <= {TW{1'b0}};
        end else if ((state_q == RUN) && (proc_done || tmr_tc_s)) begin
            cycles_q <= tmr_cnt_s + TW'(1);
        end else begin
            cycles_q <= cycles_q;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: vector table of runs plus reset/abort sequences.
module tb_run_ctrl;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int RST_CYC = 2;
    localparam int TW      = 16;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] rd_base;
    logic [AW:0]   rd_count;
    logic          busy;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          proc_reset;
    logic          req;
    logic          proc_done;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          fin;
    logic          timeout;
`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [TW-1:0] cycles;
`endif

    run_ctrl #(
        .AW(AW), .DW(DW), .RST_CYC(RST_CYC), .TW(TW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rd_base    (rd_base),
        .rd_count   (rd_count),
        .busy       (busy),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .proc_reset (proc_reset),
        .req        (req),
        .proc_done  (proc_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .fin        (fin),
        .timeout    (timeout)
`ifdef RUN_CTRL_CYCLE_CNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Data memory driven by the DUT's port; ref_mem is the bench's own expectation.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            done_at;
        bit            bp;
        int            ld_kind;
        bit            exp_to;
        int            exp_cyc;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},       busy,       32'd0);
        chk({tag, "_ld_ready"},   ld_ready,   32'd0);
        chk({tag, "_mem_wr_en"},  mem_wr_en,  32'd0);
        chk({tag, "_mem_addr"},   mem_addr,   32'd0);
        chk({tag, "_req"},        req,        32'd0);
        chk({tag, "_res_valid"},  res_valid,  32'd0);
        chk({tag, "_fin"},        fin,        32'd0);
        chk({tag, "_timeout"},    timeout,    32'd0);
        chk({tag, "_proc_reset"}, proc_reset, 32'd1);
`ifdef RUN_CTRL_CYCLE_CNT_EN
        chk({tag, "_cycles"},     cycles,     32'd0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int abort_after);
        logic [AW-1:0] la[$];
        logic [DW-1:0] ldq[$];
        int   k;
        int   n;
        int   beats;
        int   prst;
        bit   tog;
        exp_t e;

        case (v.ld_kind)
            0: begin
                for (int i = 0; i < 256; i++) begin
                    la.push_back(AW'(i));
                    ldq.push_back(DW'($urandom_range(0, 255)));
                end
            end
            1: begin
                la.push_back(8'd0); ldq.push_back(8'd5);
                la.push_back(8'd1); ldq.push_back(8'd7);
                la.push_back(8'd2); ldq.push_back(8'd9);
            end
            default: begin
                la.push_back(v.base);         ldq.push_back(DW'($urandom));
                la.push_back(v.base + 8'd1);  ldq.push_back(DW'($urandom));
            end
        endcase

        chk("idle_busy", busy, 32'd0);
        start    = 1'b1;
        rd_base  = v.base;
        rd_count = v.cnt;
        step();
        start    = 1'b0;
        rd_base  = AW'($urandom);
        rd_count = (AW+1)'($urandom);
        chk("load_ready", ld_ready, 32'd1);
        chk("start_clears_to", timeout, 32'd0);

        for (int i = 0; i < la.size(); i++) begin
            if (i == la.size() - 1) begin
                ld_valid = 1'b0;
                #1;
                chk("ld_gap_no_wr", mem_wr_en, 32'd0);
                step();
            end
            ld_valid = 1'b1;
            ld_addr  = la[i];
            ld_data  = ldq[i];
            ld_last  = (i == la.size() - 1);
            #1;
            chk("ld_wr_en", mem_wr_en, 32'd1);
            chk("ld_addr", mem_addr, la[i]);
            chk("ld_wdata", mem_wdata, ldq[i]);
            ref_mem[la[i]] = ldq[i];
            step();
        end

        // stray beats while not loading must be ignored
        ld_valid = 1'b1;
        ld_last  = 1'b0;
        ld_addr  = 8'h33;
        ld_data  = 8'hEE;
        if (!v.exp_to) begin
            for (int j = 0; j < v.cnt; j++) begin
                e.addr = v.base + AW'(j);
                e.data = ref_mem[e.addr];
                sbq.push_back(e);
            end
        end

        prst = 0;
        while (proc_reset && busy && prst < 50) begin
            chk("prst_no_wr", mem_wr_en, 32'd0);
            chk("prst_ld_ready", ld_ready, 32'd0);
            chk("prst_req", req, 32'd0);
            chk("prst_addr", mem_addr, 32'd0);
            prst++;
            step();
        end
        ld_valid = 1'b0;
        chk("prst_len", prst, RST_CYC);

        start = 1'b1;
        k = 0;
        while (!proc_reset && k < 400) begin
            chk("run_req", req, (k == 0) ? 32'd1 : 32'd0);
            chk("run_addr", mem_addr, 32'd0);
            proc_done = (k == v.done_at);
            k++;
            step();
        end
        proc_done = 1'b0;
        start     = 1'b0;
        chk("run_len", k, (v.done_at >= 0) ? v.done_at + 1 : TIMEOUT);

        beats = 0;
        tog   = 1'b0;
        n     = 0;
        while (!fin && n < 600) begin
            if (abort_after >= 0 && beats == abort_after) begin
                chk("abort_in_drain", res_valid, 32'd1);
                reset_n = 1'b0;
                #1;
                chk_reset_vals("abort");
                sbq.delete();
                res_ready = 1'b0;
                step();
                step();
                reset_n = 1'b1;
                step();
                return;
            end
            res_ready = v.bp ? tog : 1'b1;
            tog = ~tog;
            if (res_valid) begin
                if (sbq.size() == 0) begin
                    chk("extra_beat", res_valid, 32'd0);
                end else if (res_ready) begin
                    e = sbq.pop_front();
                    chk("res_addr", mem_addr, e.addr);
                    chk("res_data", res_data, e.data);
                    beats++;
                end
            end
            step();
            n++;
        end
        res_ready = 1'b0;

        chk("fin", fin, 32'd1);
        chk("timeout", timeout, v.exp_to);
        chk("beats", beats, v.exp_to ? 0 : int'(v.cnt));
        chk("sb_empty", sbq.size(), 32'd0);
`ifdef RUN_CTRL_CYCLE_CNT_EN
        chk("cycles", cycles, v.exp_cyc);
`endif
        step();
        chk("fin_pulse", fin, 32'd0);
        chk("busy_end", busy, 32'd0);
        chk("to_held", timeout, v.exp_to);
        chk("idle_proc_reset", proc_reset, 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t av;

        reset_n   = 1'b0;
        start     = 1'b0;
        rd_base   = 8'd0;
        rd_count  = 9'd0;
        ld_valid  = 1'b0;
        ld_addr   = 8'd0;
        ld_data   = 8'd0;
        ld_last   = 1'b0;
        proc_done = 1'b0;
        res_ready = 1'b0;

        vecs[0] = '{base: 8'd0,   cnt: 9'd0, done_at: 3,  bp: 1'b0, ld_kind: 0, exp_to: 1'b0, exp_cyc: 4};
        vecs[1] = '{base: 8'd64,  cnt: 9'd2, done_at: 9,  bp: 1'b0, ld_kind: 1, exp_to: 1'b0, exp_cyc: 10};
        vecs[2] = '{base: 8'd255, cnt: 9'd3, done_at: 4,  bp: 1'b1, ld_kind: 2, exp_to: 1'b0, exp_cyc: 5};
        vecs[3] = '{base: 8'd10,  cnt: 9'd2, done_at: -1, bp: 1'b0, ld_kind: 2, exp_to: 1'b1, exp_cyc: TIMEOUT};
        vecs[4] = '{base: 8'd20,  cnt: 9'd0, done_at: TIMEOUT - 1, bp: 1'b0, ld_kind: 2, exp_to: 1'b0, exp_cyc: TIMEOUT};
        vecs[5] = '{base: 8'd128, cnt: 9'd4, done_at: 0,  bp: 1'b1, ld_kind: 2, exp_to: 1'b0, exp_cyc: 1};

        step();
        step();
        chk_reset_vals("in_reset");
        reset_n = 1'b1;
        step();
        chk_reset_vals("idle");

        start    = 1'b1;
        rd_base  = 8'd0;
        rd_count = 9'd1;
        step();
        start = 1'b0;
        chk("empty_load_ready", ld_ready, 32'd1);
        chk("empty_load_busy", busy, 32'd1);
        chk("empty_load_no_wr", mem_wr_en, 32'd0);
        step();
        chk("load_waits", ld_ready, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("load_abort");
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], -1);
        end

        av = '{base: 8'd0, cnt: 9'd4, done_at: 2, bp: 1'b0, ld_kind: 2, exp_to: 1'b0, exp_cyc: 3};
        run_vec(av, 1);
        chk_reset_vals("post_abort");
        run_vec(vecs[1], -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
